// File: rtl/irq_encoder8to3.sv
// rtl/irq_encoder8to3.sv - 8-to-3 interrupt request encoder with pending capture and valid/ack grant
module irq_encoder8to3 #(
    parameter bit EDGE_MODE  = 1'b1,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic       clr_ovr,
    output logic       valid,
    output logic [2:0] code,
    output logic [7:0] pending,
    output logic       overrun
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] req_d_q;
    logic       overrun_q, overrun_d;

    logic [7:0] evt;
    logic [7:0] clr;
    logic [7:0] cand;
    logic       ovr_set;

    function automatic logic [2:0] pick(input logic [7:0] c);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (c[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (c[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        evt = EDGE_MODE ? (req & ~req_d_q) : req;
        clr = (state_q == BUSY && ack) ? (8'h01 << code_q) : 8'h00;
        // A new event on a bit being acknowledged survives the clear.
        pending_d = evt | (pending_q & ~clr);
        ovr_set   = EDGE_MODE && (|(evt & pending_q & ~clr));
        overrun_d = ovr_set | (overrun_q & ~clr_ovr);
        cand      = pending_q & ~mask;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (en && (|cand)) begin
                    code_d  = pick(cand);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= 3'd0;
            pending_q <= 8'h00;
            req_d_q   <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            req_d_q   <= req;
            overrun_q <= overrun_d;
        end
    end

    assign valid   = (state_q == BUSY);
    assign code    = code_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_encoder8to3.sv
// tb/tb_irq_encoder8to3.sv - directed checks of irq_encoder8to3 in edge/level and both priority orders
module tb_irq_encoder8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       clr_ovr;

    logic       valid, valid_lo, valid_lv;
    logic [2:0] code, code_lo, code_lv;
    logic [7:0] pending, pending_lo, pending_lv;
    logic       overrun, overrun_lo, overrun_lv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_encoder8to3 #(.EDGE_MODE(1'b1), .HIGH_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask), .ack(ack),
        .clr_ovr(clr_ovr), .valid(valid), .code(code), .pending(pending), .overrun(overrun)
    );

    irq_encoder8to3 #(.EDGE_MODE(1'b1), .HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask), .ack(ack),
        .clr_ovr(clr_ovr), .valid(valid_lo), .code(code_lo), .pending(pending_lo),
        .overrun(overrun_lo)
    );

    irq_encoder8to3 #(.EDGE_MODE(1'b0), .HIGH_FIRST(1'b1)) dut_lv (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask), .ack(ack),
        .clr_ovr(clr_ovr), .valid(valid_lv), .code(code_lv), .pending(pending_lv),
        .overrun(overrun_lv)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] req_val);
        rst_n   = 1'b0;
        en      = 1'b1;
        req     = req_val;
        mask    = 8'h00;
        ack     = 1'b0;
        clr_ovr = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with all requests high
        do_reset(8'hFF);
        rst_n = 1'b0;
        #1;
        check("rst_valid",   8'(valid), 8'h00);
        check("rst_pending", pending, 8'h00);
        check("rst_code",    8'(code), 8'h00);
        check("rst_overrun", 8'(overrun), 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("ff_pending", pending, 8'hFF);
        check("ff_valid0",  8'(valid), 8'h00);
        tick();
        check("ff_valid1",  8'(valid), 8'h01);
        check("ff_code",    8'(code), 8'h07);

        // Single pulse on line 3
        do_reset(8'h00);
        req = 8'h08;
        tick();
        check("p3_pending", pending, 8'h08);
        check("p3_valid0",  8'(valid), 8'h00);
        req = 8'h00;
        tick();
        check("p3_valid1",  8'(valid), 8'h01);
        check("p3_code",    8'(code), 8'h03);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("p3_ack_valid",   8'(valid), 8'h00);
        check("p3_ack_pending", pending, 8'h00);

        // Two lines together, both priority orders
        do_reset(8'h00);
        req = 8'h22;
        tick();
        req = 8'h00;
        tick();
        check("pr_code_a",    8'(code), 8'h05);
        check("pr_lo_code_a", 8'(code_lo), 8'h01);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("pr_gap_valid",   8'(valid), 8'h00);
        check("pr_pending_a",   pending, 8'h02);
        check("pr_lo_pending_a", pending_lo, 8'h20);
        tick();
        check("pr_valid_b",   8'(valid), 8'h01);
        check("pr_code_b",    8'(code), 8'h01);
        check("pr_lo_code_b", 8'(code_lo), 8'h05);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("pr_pending_end",    pending, 8'h00);
        check("pr_lo_pending_end", pending_lo, 8'h00);

        // Grant frozen while BUSY despite new higher request and mask change
        do_reset(8'h00);
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        check("bz_code_a", 8'(code), 8'h02);
        req  = 8'h40;
        mask = 8'h04;
        tick();
        req = 8'h00;
        check("bz_pending", pending, 8'h44);
        tick();
        check("bz_hold_code",  8'(code), 8'h02);
        check("bz_hold_valid", 8'(valid), 8'h01);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("bz_pending2", pending, 8'h40);
        tick();
        check("bz_code_b", 8'(code), 8'h06);
        ack = 1'b1;
        tick();
        ack  = 1'b0;
        mask = 8'h00;

        // Fully masked, then en low, then en high; ack in IDLE ignored
        do_reset(8'h00);
        mask = 8'hFF;
        req  = 8'h10;
        tick();
        req = 8'h00;
        check("mk_pending", pending, 8'h10);
        tick();
        check("mk_valid_a", 8'(valid), 8'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle_ack_pending", pending, 8'h10);
        en   = 1'b0;
        mask = 8'h00;
        tick();
        tick();
        check("en0_valid", 8'(valid), 8'h00);
        en = 1'b1;
        tick();
        check("en1_valid", 8'(valid), 8'h01);
        check("en1_code",  8'(code), 8'h04);

        // Overrun set, hold, clear; set-wins on ack of same line
        do_reset(8'h00);
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        req = 8'h08;
        tick();
        check("ov_set",    8'(overrun), 8'h01);
        check("ov_lv_off", 8'(overrun_lv), 8'h00);
        req = 8'h00;
        tick();
        check("ov_hold", 8'(overrun), 8'h01);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ov_clr", 8'(overrun), 8'h00);
        req = 8'h08;
        ack = 1'b1;
        tick();
        req = 8'h00;
        ack = 1'b0;
        check("sw_pending", pending, 8'h08);
        check("sw_overrun", 8'(overrun), 8'h00);
        check("sw_valid",   8'(valid), 8'h00);
        tick();
        check("sw_regrant", 8'(code), 8'h03);
        check("sw_valid1",  8'(valid), 8'h01);

        // Asynchronous reset mid-grant
        rst_n = 1'b0;
        #1;
        check("ar_valid",   8'(valid), 8'h00);
        check("ar_pending", pending, 8'h00);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
